m_tile_renderer: RTL

// - Reader side of the maze/food memories and position bus driven by game logic.
// - On enable, sweeps every maze tile row-major, reads wall and food bits, and resolves a tile colour from the wall/food bits and the player/ghost positions.
// - Emits pixel writes (x, y, colour, plot) to the 160x120 VGA adapter, then raises finished for the top-level sequencer.

---
 rtl/m_tile_renderer_pkg.sv | 33 +++
 rtl/m_tile_renderer_if.sv | 38 +++
 rtl/m_tile_colour.sv | 34 +++
 rtl/m_tile_renderer.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/m_tile_renderer_pkg.sv
// Shared constants for the maze renderer: geometry defaults, tile colours and FSM encoding.
// Game logic imports the same geometry so both sides agree on the maze size.
package m_tile_renderer_pkg;

    localparam int DEF_COLS    = 29;
    localparam int DEF_ROWS    = 16;
    localparam int DEF_TILE    = 5;
    localparam int DEF_RAM_LAT = 2;

    localparam logic [2:0] C_PLAYER = 3'b110;
    localparam logic [2:0] C_GHOST1 = 3'b100;
    localparam logic [2:0] C_GHOST2 = 3'b101;
    localparam logic [2:0] C_GHOST3 = 3'b011;
    localparam logic [2:0] C_WALL   = 3'b001;
    localparam logic [2:0] C_FOOD   = 3'b111;
    localparam logic [2:0] C_BLACK  = 3'b000;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WAIT = 3'd1,
        S_DRAW = 3'd2,
        S_NEXT = 3'd3,
        S_DONE = 3'd4
    } state_t;

    typedef struct packed {
        logic player;
        logic ghost1;
        logic ghost2;
        logic ghost3;
    } match_t;

endpackage

// File: rtl/m_tile_renderer_if.sv
// Bundle of everything the renderer exchanges with the sequencer, game logic, maze RAMs and VGA adapter.
interface m_tile_renderer_if;

    // enable/finished is a level handshake: the sequencer raises enable and holds it until
    // finished rises, then drops it, which returns the renderer to idle and clears finished.
    // Pixel writes have no back-pressure: the adapter takes every cycle with vga_plot high.
    logic       enable;
    logic       finished;
    logic [4:0] player_x;
    logic [3:0] player_y;
    logic [4:0] ghost1_x;
    logic [3:0] ghost1_y;
    logic [4:0] ghost2_x;
    logic [3:0] ghost2_y;
    logic [4:0] ghost3_x;
    logic [3:0] ghost3_y;
    logic [8:0] address_wall;
    logic       wall_q;
    logic [8:0] address_food;
    logic       food_q;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;

    modport master (
        output enable, player_x, player_y, ghost1_x, ghost1_y, ghost2_x, ghost2_y,
               ghost3_x, ghost3_y, wall_q, food_q,
        input  finished, address_wall, address_food, vga_x, vga_y, vga_colour, vga_plot
    );

    modport slave (
        input  enable, player_x, player_y, ghost1_x, ghost1_y, ghost2_x, ghost2_y,
               ghost3_x, ghost3_y, wall_q, food_q,
        output finished, address_wall, address_food, vga_x, vga_y, vga_colour, vga_plot
    );

endinterface

// File: rtl/m_tile_colour.sv
// Priority resolver for one pixel: sprites over walls over food; food lights only the tile centre.
module m_tile_colour
    import m_tile_renderer_pkg::*;
#(
    parameter int TILE = DEF_TILE
) (
    input  logic       i_wall,
    input  logic       i_food,
    input  logic [2:0] i_px,
    input  logic [2:0] i_py,
    input  match_t     i_match,
    output logic [2:0] o_colour
);

    localparam logic [2:0] CENTRE = 3'(TILE / 2);

    always_comb begin
        o_colour = C_BLACK;
        if (i_match.player) begin
            o_colour = C_PLAYER;
        end else if (i_match.ghost1) begin
            o_colour = C_GHOST1;
        end else if (i_match.ghost2) begin
            o_colour = C_GHOST2;
        end else if (i_match.ghost3) begin
            o_colour = C_GHOST3;
        end else if (i_wall) begin
            o_colour = C_WALL;
        end else if (i_food && (i_px == CENTRE) && (i_py == CENTRE)) begin
            o_colour = C_FOOD;
        end
    end

endmodule

// File: rtl/m_tile_renderer.sv
// Sweeps the maze tile by tile, reads wall/food bits and plots each tile's pixels to the VGA adapter.
// Sprite positions are snapshotted at start so the whole frame is drawn from one consistent game state.
module m_tile_renderer
    import m_tile_renderer_pkg::*;
#(
    parameter int COLS    = DEF_COLS,
    parameter int ROWS    = DEF_ROWS,
    parameter int TILE    = DEF_TILE,
    parameter int RAM_LAT = DEF_RAM_LAT
) (
    input  logic              clock,
    input  logic              resetn,
    m_tile_renderer_if.slave  bus,
    output state_t            o_state
);

    localparam int         N_TILES   = COLS * ROWS;
    localparam logic [8:0] LAST_TILE = 9'(N_TILES - 1);
    localparam logic [4:0] LAST_COL  = 5'(COLS - 1);
    localparam logic [2:0] LAST_PIX  = 3'(TILE - 1);
    localparam logic [1:0] LAST_WAIT = 2'(RAM_LAT - 1);
    localparam logic [7:0] STEP_X    = 8'(TILE);
    localparam logic [6:0] STEP_Y    = 7'(TILE);

    state_t     r_state;
    state_t     w_next;
    logic [8:0] r_tile;
    logic [4:0] r_col;
    logic [3:0] r_row;
    logic [7:0] r_base_x;
    logic [6:0] r_base_y;
    logic [2:0] r_px;
    logic [2:0] r_py;
    logic [1:0] r_wait;
    logic       r_wall;
    logic       r_food;
    logic       r_finished;
    logic [4:0] r_player_x;
    logic [3:0] r_player_y;
    logic [4:0] r_ghost1_x;
    logic [3:0] r_ghost1_y;
    logic [4:0] r_ghost2_x;
    logic [3:0] r_ghost2_y;
    logic [4:0] r_ghost3_x;
    logic [3:0] r_ghost3_y;

    logic       w_draw;
    logic       w_tile_end;
    match_t     w_match;
    logic [2:0] w_colour;

    assign w_draw     = (r_state == S_DRAW);
    assign w_tile_end = (r_px == LAST_PIX) && (r_py == LAST_PIX);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // DONE is left only once finished has been shown, so the sequencer always sees it.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (bus.enable) w_next = S_WAIT;
            S_WAIT:  if (r_wait == LAST_WAIT) w_next = S_DRAW;
            S_DRAW:  if (w_tile_end) w_next = S_NEXT;
            S_NEXT:  w_next = (r_tile == LAST_TILE) ? S_DONE : S_WAIT;
            S_DONE:  if (!bus.enable && r_finished) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_tile     <= '0;
            r_col      <= '0;
            r_row      <= '0;
            r_base_x   <= '0;
            r_base_y   <= '0;
            r_px       <= '0;
            r_py       <= '0;
            r_wait     <= '0;
            r_wall     <= 1'b0;
            r_food     <= 1'b0;
            r_finished <= 1'b0;
            r_player_x <= '0;
            r_player_y <= '0;
            r_ghost1_x <= '0;
            r_ghost1_y <= '0;
            r_ghost2_x <= '0;
            r_ghost2_y <= '0;
            r_ghost3_x <= '0;
            r_ghost3_y <= '0;
        end else begin
            r_finished <= (r_state == S_DONE) && (w_next == S_DONE);
            unique case (r_state)
                S_IDLE: begin
                    if (bus.enable) begin
                        r_player_x <= bus.player_x;
                        r_player_y <= bus.player_y;
                        r_ghost1_x <= bus.ghost1_x;
                        r_ghost1_y <= bus.ghost1_y;
                        r_ghost2_x <= bus.ghost2_x;
                        r_ghost2_y <= bus.ghost2_y;
                        r_ghost3_x <= bus.ghost3_x;
                        r_ghost3_y <= bus.ghost3_y;
                        r_tile     <= '0;
                        r_col      <= '0;
                        r_row      <= '0;
                        r_base_x   <= '0;
                        r_base_y   <= '0;
                        r_wait     <= '0;
                    end
                end
                S_WAIT: begin
                    if (r_wait == LAST_WAIT) begin
                        r_wait <= '0;
                        r_wall <= bus.wall_q;
                        r_food <= bus.food_q;
                        r_px   <= '0;
                        r_py   <= '0;
                    end else begin
                        r_wait <= r_wait + 2'd1;
                    end
                end
                S_DRAW: begin
                    if (r_px == LAST_PIX) begin
                        r_px <= '0;
                        r_py <= (r_py == LAST_PIX) ? 3'd0 : r_py + 3'd1;
                    end else begin
                        r_px <= r_px + 3'd1;
                    end
                end
                S_NEXT: begin
                    if (r_tile != LAST_TILE) begin
                        r_tile <= r_tile + 9'd1;
                        if (r_col == LAST_COL) begin
                            r_col    <= '0;
                            r_base_x <= '0;
                            r_row    <= r_row + 4'd1;
                            r_base_y <= r_base_y + STEP_Y;
                        end else begin
                            r_col    <= r_col + 5'd1;
                            r_base_x <= r_base_x + STEP_X;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Off-maze positions can never equal a live column/row, so they simply never match.
    always_comb begin
        w_match        = '0;
        w_match.player = (r_col == r_player_x) && (r_row == r_player_y);
        w_match.ghost1 = (r_col == r_ghost1_x) && (r_row == r_ghost1_y);
        w_match.ghost2 = (r_col == r_ghost2_x) && (r_row == r_ghost2_y);
        w_match.ghost3 = (r_col == r_ghost3_x) && (r_row == r_ghost3_y);
    end

    m_tile_colour #(
        .TILE (TILE)
    ) u_colour (
        .i_wall   (r_wall),
        .i_food   (r_food),
        .i_px     (r_px),
        .i_py     (r_py),
        .i_match  (w_match),
        .o_colour (w_colour)
    );

    assign bus.address_wall = r_tile;
    assign bus.address_food = r_tile;
    assign bus.finished     = r_finished;
    assign bus.vga_plot     = w_draw;
    assign bus.vga_x        = w_draw ? (r_base_x + {5'd0, r_px}) : 8'd0;
    assign bus.vga_y        = w_draw ? (r_base_y + {4'd0, r_py}) : 7'd0;
    assign bus.vga_colour   = w_draw ? w_colour : C_BLACK;
    assign o_state          = r_state;

endmodule
